// File: rtl/rv32_pkg.sv
// Shared constants for the RISC32-SC integer datapath: widths, register count
// and ABI register indices used by the register file and its benches.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [AW-1:0] REG_ZERO = '0;

    // ABI names for the low registers; benches use these instead of bare numbers.
    localparam logic [AW-1:0] RA = 5'd1;
    localparam logic [AW-1:0] SP = 5'd2;
    localparam logic [AW-1:0] GP = 5'd3;
    localparam logic [AW-1:0] TP = 5'd4;
    localparam logic [AW-1:0] T0 = 5'd5;
    localparam logic [AW-1:0] T1 = 5'd6;
    localparam logic [AW-1:0] T2 = 5'd7;
    localparam logic [AW-1:0] S0 = 5'd8;
    localparam logic [AW-1:0] S1 = 5'd9;
    localparam logic [AW-1:0] A0 = 5'd10;
    localparam logic [AW-1:0] A1 = 5'd11;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Operand/writeback bundle between the core and regfile_2r1w.
// Optional debug read port exists only when REGFILE_DBG_PORT_EN is defined.
interface regfile_2r1w_if;
    import rv32_pkg::*;

    // No handshake: every field is sampled each cycle. Reads and stall are
    // combinational on the current inputs; we/rsv_v take effect on the next rising edge.
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            rsv_v;
    logic [AW-1:0]   rsv_a;
    logic            rd_use1;
    logic            rd_use2;
    logic            stall;
    logic [NREG-1:0] pend;
`ifdef REGFILE_DBG_PORT_EN
    logic [AW-1:0]   dbg_a;
    logic [XLEN-1:0] dbg_d;
`endif

    modport master (
        output ra1, ra2, we, wa, wd, rsv_v, rsv_a, rd_use1, rd_use2,
`ifdef REGFILE_DBG_PORT_EN
        output dbg_a,
        input  dbg_d,
`endif
        input  rd1, rd2, stall, pend
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, rsv_v, rsv_a, rd_use1, rd_use2,
`ifdef REGFILE_DBG_PORT_EN
        input  dbg_a,
        output dbg_d,
`endif
        output rd1, rd2, stall, pend
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a reservation and
// cleared by the retiring write; raises stall for consumed pending sources.
module regfile_scoreboard
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rsv_v,
    input  logic [AW-1:0]   rsv_a,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic            rd_use1,
    input  logic            rd_use2,
    output logic [NREG-1:0] pend,
    output logic            stall
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_next;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic            hit1;
    logic            hit2;

    // Set is OR-ed in after the clear so a new reservation beats a retiring write.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rsv_v && rsv_a != REG_ZERO) set_vec[rsv_a] = 1'b1;
        if (we && wa != REG_ZERO)       clr_vec[wa]    = 1'b1;
        pend_next = (pend_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_next;
    end

    always_comb begin
        hit1 = rd_use1 && (ra1 != REG_ZERO) && pend_q[ra1] && !(we && wa == ra1);
        hit2 = rd_use2 && (ra2 != REG_ZERO) && pend_q[ra2] && !(we && wa == ra2);
    end

    assign stall = hit1 || hit2;
    assign pend  = pend_q;

endmodule

// File: rtl/regfile_2r1w.sv
// 32x32 integer register file, two combinational read ports with write-first
// bypass, x0 hard-wired to zero, plus pending-write scoreboard.
// Define REGFILE_DBG_PORT_EN to add a bypass-free debug read port.
module regfile_2r1w
    import rv32_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    regfile_2r1w_if.slave bus
);

    logic [XLEN-1:0] regs [NREG];

    // regs[0] is only ever reset, never written, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.we && bus.wa != REG_ZERO) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    always_comb begin
        if (bus.ra1 == REG_ZERO)                 bus.rd1 = '0;
        else if (bus.we && bus.wa == bus.ra1)    bus.rd1 = bus.wd;
        else                                     bus.rd1 = regs[bus.ra1];

        if (bus.ra2 == REG_ZERO)                 bus.rd2 = '0;
        else if (bus.we && bus.wa == bus.ra2)    bus.rd2 = bus.wd;
        else                                     bus.rd2 = regs[bus.ra2];
    end

`ifdef REGFILE_DBG_PORT_EN
    assign bus.dbg_d = (bus.dbg_a == REG_ZERO) ? '0 : regs[bus.dbg_a];
`endif

    regfile_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .rsv_v   (bus.rsv_v),
        .rsv_a   (bus.rsv_a),
        .we      (bus.we),
        .wa      (bus.wa),
        .ra1     (bus.ra1),
        .ra2     (bus.ra2),
        .rd_use1 (bus.rd_use1),
        .rd_use2 (bus.rd_use2),
        .pend    (bus.pend),
        .stall   (bus.stall)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed and reference-model bench for regfile_2r1w.
// Also exercises the debug port when REGFILE_DBG_PORT_EN is defined.
module tb_regfile_2r1w;
    import rv32_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [31:0] e1, e2;
    logic        es;

    regfile_2r1w_if bus ();

    regfile_2r1w dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.we = 1'b0;  bus.wa = '0;  bus.wd = '0;
        bus.rsv_v = 1'b0; bus.rsv_a = '0;
        bus.ra1 = '0;   bus.ra2 = '0;
        bus.rd_use1 = 1'b0; bus.rd_use2 = 1'b0;
    endtask

    // Inputs change 1ns after the rising edge; checks follow 1ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        idle();
`ifdef REGFILE_DBG_PORT_EN
        bus.dbg_a = '0;
`endif
        #12;
        bus.ra1 = T0;
        #1;
        chk("reset_rd1", bus.rd1, 32'h0);
        chk("reset_pend", bus.pend, 32'h0);
        chk("reset_stall", {31'd0, bus.stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: asynchronous reset wipes data and reservations without a clock edge
        bus.we = 1'b1; bus.wa = T0; bus.wd = 32'hDEADBEEF;
        bus.rsv_v = 1'b1; bus.rsv_a = T1;
        next_cycle();
        idle();
        bus.ra1 = T0; bus.ra2 = T1; bus.rd_use2 = 1'b1;
        #1;
        chk("t1_rd1_before", bus.rd1, 32'hDEADBEEF);
        chk("t1_pend_before", bus.pend, 32'h0000_0040);
        chk("t1_stall_before", {31'd0, bus.stall}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_rd1_async", bus.rd1, 32'h0);
        chk("t1_pend_async", bus.pend, 32'h0);
        chk("t1_stall_async", {31'd0, bus.stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // 2: x0 ignores writes
        bus.we = 1'b1; bus.wa = REG_ZERO; bus.wd = 32'hFFFFFFFF; bus.ra1 = REG_ZERO;
        #1;
        chk("t2_x0_same_cycle", bus.rd1, 32'h0);
        next_cycle();
        bus.we = 1'b0;
        #1;
        chk("t2_x0_after", bus.rd1, 32'h0);

        // 3: write-first bypass, then array
        bus.we = 1'b1; bus.wa = T2; bus.wd = 32'h12345678; bus.ra1 = T2;
        #1;
        chk("t3_bypass", bus.rd1, 32'h12345678);
        next_cycle();
        bus.we = 1'b0;
        #1;
        chk("t3_array", bus.rd1, 32'h12345678);
`ifdef REGFILE_DBG_PORT_EN
        bus.dbg_a = T2;
        bus.we = 1'b1; bus.wa = T2; bus.wd = 32'h0BAD0BAD;
        #1;
        chk("dbg_no_bypass", bus.dbg_d, 32'h12345678);
        bus.we = 1'b0; bus.dbg_a = REG_ZERO;
        #1;
        chk("dbg_x0", bus.dbg_d, 32'h0);
`endif

        // 4: stall on a reserved source and release by the retiring write
        idle();
        bus.rsv_v = 1'b1; bus.rsv_a = GP;
        next_cycle();
        bus.rsv_v = 1'b0;
        bus.ra2 = GP; bus.rd_use2 = 1'b1;
        #1;
        chk("t4_stall", {31'd0, bus.stall}, 32'h1);
        chk("t4_pend", bus.pend, 32'h0000_0008);
        bus.rd_use2 = 1'b0;
        #1;
        chk("t4_no_use", {31'd0, bus.stall}, 32'h0);
        bus.rd_use2 = 1'b1;
        bus.we = 1'b1; bus.wa = GP; bus.wd = 32'h000000A5;
        #1;
        chk("t4_release_stall", {31'd0, bus.stall}, 32'h0);
        chk("t4_release_rd2", bus.rd2, 32'h000000A5);
        next_cycle();
        bus.we = 1'b0;
        #1;
        chk("t4_pend_clear", bus.pend, 32'h0);
        chk("t4_stall_after", {31'd0, bus.stall}, 32'h0);
        chk("t4_rd2_after", bus.rd2, 32'h000000A5);

        // 5: set beats clear; rsv_a==0 ignored; re-reserve leaves a single bit
        idle();
        bus.rsv_v = 1'b1; bus.rsv_a = S1;
        next_cycle();
        bus.rsv_v = 1'b1; bus.rsv_a = S1;
        bus.we = 1'b1; bus.wa = S1; bus.wd = 32'h5555AAAA;
        next_cycle();
        idle();
        bus.ra1 = S1; bus.rd_use1 = 1'b1;
        #1;
        chk("t5_pend_kept", bus.pend, 32'h0000_0200);
        chk("t5_reg_written", bus.rd1, 32'h5555AAAA);
        chk("t5_stall", {31'd0, bus.stall}, 32'h1);
        bus.rd_use1 = 1'b0;
        bus.rsv_v = 1'b1; bus.rsv_a = REG_ZERO;
        next_cycle();
        bus.rsv_v = 1'b1; bus.rsv_a = S1;
        next_cycle();
        bus.rsv_v = 1'b0;
        #1;
        chk("t5_x0_and_rereserve", bus.pend, 32'h0000_0200);
        bus.we = 1'b1; bus.wa = S1; bus.wd = 32'h1;
        next_cycle();
        bus.we = 1'b0;
        #1;
        chk("t5_single_clear", bus.pend, 32'h0);

        // 6: random traffic against a reference model, starting from reset
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pend = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            bus.we      = 1'($urandom_range(0, 1));
            bus.wa      = 5'($urandom_range(0, 7));
            bus.wd      = $urandom;
            bus.rsv_v   = ($urandom_range(0, 3) == 0);
            bus.rsv_a   = 5'($urandom_range(0, 7));
            bus.ra1     = 5'($urandom_range(0, 7));
            bus.ra2     = 5'($urandom_range(0, 7));
            bus.rd_use1 = 1'($urandom_range(0, 1));
            bus.rd_use2 = 1'($urandom_range(0, 1));
            #1;
            e1 = (bus.ra1 == 0) ? 32'h0 : (bus.we && bus.wa == bus.ra1) ? bus.wd : m_regs[bus.ra1];
            e2 = (bus.ra2 == 0) ? 32'h0 : (bus.we && bus.wa == bus.ra2) ? bus.wd : m_regs[bus.ra2];
            es = (bus.rd_use1 && bus.ra1 != 0 && m_pend[bus.ra1] && !(bus.we && bus.wa == bus.ra1)) ||
                 (bus.rd_use2 && bus.ra2 != 0 && m_pend[bus.ra2] && !(bus.we && bus.wa == bus.ra2));
            chk("rnd_rd1", bus.rd1, e1);
            chk("rnd_rd2", bus.rd2, e2);
            chk("rnd_pend", bus.pend, m_pend);
            chk("rnd_stall", {31'd0, bus.stall}, {31'd0, es});
            @(posedge clk);
            if (bus.we && bus.wa != 0) begin
                m_regs[bus.wa] = bus.wd;
                m_pend[bus.wa] = 1'b0;
            end
            if (bus.rsv_v && bus.rsv_a != 0) m_pend[bus.rsv_a] = 1'b1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Integer register file for the RISC32-SC core: 32 x 32-bit, two read ports, one write port.
- Consumes the writeback value (pc+4 / immExt / alu_result / Do, already selected upstream) and produces A_data/B_data for the ALU-operand selectors.
- Write-first bypass and x0 hard-wired to zero.
- Includes a pending-write scoreboard: multi-cycle producers reserve rd at issue, and a stall is raised for readers of reserved registers.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of registers; power of 2.
- AW, 5, address width; must equal log2(NREG).

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra1  in  AW  read address port 1 (rs1).
- ra2  in  AW  read address port 2 (rs2).
- rd1  out  XLEN  read data 1 (A_data).
- rd2  out  XLEN  read data 2 (B_data).
- we  in  1  write enable (regwrite).
- wa  in  AW  write address (rd).
- wd  in  XLEN  write data (writeback mux output).
- rsv_v  in  1  reserve request: a multi-cycle op will later write rsv_a.
- rsv_a  in  AW  register to reserve.
- rd_use1  in  1  ra1 is actually consumed this cycle.
- rd_use2  in  1  ra2 is actually consumed this cycle.
- stall  out  1  a consumed source register is pending.
- pend  out  NREG  scoreboard bit-vector; bit i = register i pending.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0 and pend = 0, immediately, independent of clk.
  - rd1/rd2 then read 0; stall = 0.
- Write: on posedge clk with we=1 and wa!=0, reg[wa] <= wd.
  - Writes to x0 are ignored; reg[0] always reads 0.
- Read: combinational, zero-latency.
  - rdN = 0 if raN==0.
  - Otherwise, if we && wa==raN, rdN = wd (write-first bypass).
  - Otherwise rdN = reg[raN].
- Scoreboard, per register i != 0, on posedge:
  - set = rsv_v && rsv_a==i
  - clr = we && wa==i
  - clr && !set -> pend[i] <= 0
  - set -> pend[i] <= 1; set wins over clr on the same cycle (new reservation supersedes the retiring write).
  - Neither -> hold.
  - pend[0] is always 0; rsv_a==0 is ignored.
- Reserving an already-pending register is legal and leaves the bit at 1. No counting: one write clears the bit.
- stall (combinational) = (rd_use1 && ra1!=0 && pend[ra1] && !(we && wa==ra1)) || (same term for port 2).
  - A write retiring in the same cycle releases the stall via the bypass.
- Write without a reservation: normal write; pend is unchanged if it was already 0.
- Reset mid-operation: all reservations are dropped and stall falls asynchronously with rst_n.
- Latency: read 0 cycles; write visible through the array one cycle later, and immediately through the bypass.

Optional Feature:
- Macro: REGFILE_DBG_PORT_EN.
- Defined: adds a third combinational read port.
  - dbg_a in AW, dbg_d out XLEN.
  - dbg_d = reg[dbg_a], no bypass, and 0 for dbg_a==0.
  - Intended for the testbench / debug halt dump.
- Undefined: the ports do not exist; no extra logic.

Decomposition:
- Shared package rv32_pkg: XLEN, NREG, AW constants; REG_ZERO = 0; ABI register-index constants (RA=1, SP=2, ...) for benches.
- One natural sub-module: regfile_scoreboard, holding the pend vector, set/clr priority and stall logic.
  - Its inputs: rsv_v/rsv_a, we/wa, ra1/ra2, rd_use1/rd_use2.
  - Kept separate so it can be reused by a future pipelined core.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle after writing x5=0xDEADBEEF -> rd1 with ra1=5 reads 0 without a clock edge; pend=0.
2. x0 protection: we=1, wa=0, wd=0xFFFFFFFF, then ra1=0 -> rd1=0.
3. Bypass and write: same cycle we=1, wa=7, wd=0x12345678, ra1=7 -> rd1=0x12345678 in that cycle and after the edge with we=0.
4. Stall and release:
   - rsv_v=1, rsv_a=3; next cycle ra2=3, rd_use2=1 -> stall=1.
   - Then we=1, wa=3, wd=0xA5 -> stall=0, rd2=0xA5, pend[3]=0 after the edge.
   - With rd_use2=0 -> stall=0 throughout.
5. Set/clear collision: pend[9]=1; same cycle rsv_v=1, rsv_a=9 and we=1, wa=9 -> after the edge pend[9]=1 and reg[9]=wd.
6. Random: 10k cycles of random we/wa/wd/rsv/ra against a reference model -> rd1, rd2, pend, stall match every cycle.
